// File: rtl/multi_edge_detector_if.sv
// Channel bus of multi_edge_detector: raw inputs and controls go in; filtered levels,
// edge pulses, sticky flags and the combined interrupt come out.
interface multi_edge_detector_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] flag;
    logic             irq;

    modport master (
        output din, mode, clr,
        input  level, rise, fall, pulse, flag, irq
    );

    modport slave (
        input  din, mode, clr,
        output level, rise, fall, pulse, flag, irq
    );
endinterface

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser and debounce filter, one-cycle
// rise/fall pulses, mode-gated pulses and write-1-to-clear sticky flags with an interrupt.
module multi_edge_detector #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    multi_edge_detector_if.slave bus
);
    localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] flag_q,  flag_d;
    logic [WIDTH-1:0] commit;

    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign s = bus.din;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];

            // NOTE: sequential state uses non-blocking assignments so every flop samples
            // the pre-edge value of its neighbour; blocking here would collapse the chain.
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
                end else begin
                    sync_q[0] <= bus.din;
                    for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
                end
            end

            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // NOTE: every variable gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        level_d = level_q;
        commit  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    commit[i]  = 1'b1;
                    level_d[i] = s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // A commit always flips the level, so the new level tells rise from fall.
    always_comb begin
        rise_d  = commit & level_d;
        fall_d  = commit & level_q;
        pulse_d = (rise_d & {WIDTH{bus.mode[0]}}) | (fall_d & {WIDTH{bus.mode[1]}});
        flag_d  = (flag_q & ~bus.clr) | pulse_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.level = level_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.pulse = pulse_q;
    assign bus.flag  = flag_q;
    assign bus.irq   = |flag_q;
endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3):
// hand-computed expectations checked with immediate assertions after each rising edge.
module tb_multi_edge_detector;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    logic [3:0] seen;

    multi_edge_detector_if #(.WIDTH(4)) bus ();

    multi_edge_detector #(
        .WIDTH      (4),
        .SYNC_STAGES(2),
        .FILTER_LEN (3)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Outputs are sampled 1 time unit after the edge; inputs set here are taken at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        resetn   = 1'b0;
        bus.din  = 4'hF;
        bus.mode = 2'b01;
        bus.clr  = 4'h0;

        // Reset with inputs high, then release: rise on all channels 4 edges later.
        tick();
        check("rst1_level", bus.level, 4'h0);
        check("rst1_rise",  bus.rise,  4'h0);
        check("rst1_fall",  bus.fall,  4'h0);
        check("rst1_pulse", bus.pulse, 4'h0);
        check("rst1_flag",  bus.flag,  4'h0);
        check("rst1_irq",   bus.irq,   1'b0);
        tick();
        check("rst2_pulse", bus.pulse, 4'h0);
        check("rst2_flag",  bus.flag,  4'h0);
        resetn = 1'b1;
        ticks(4);
        check("rel_k3_rise", bus.rise, 4'h0);
        check("rel_k3_irq",  bus.irq,  1'b0);
        tick();
        check("rel_k4_rise",  bus.rise,  4'hF);
        check("rel_k4_pulse", bus.pulse, 4'hF);
        check("rel_k4_level", bus.level, 4'hF);
        check("rel_k4_flag",  bus.flag,  4'hF);
        check("rel_k4_irq",   bus.irq,   1'b1);
        tick();
        check("rel_k5_rise",  bus.rise,  4'h0);
        check("rel_k5_pulse", bus.pulse, 4'h0);

        // Drop all inputs and clear flags; falls are not reported with mode=01.
        bus.din = 4'h0;
        bus.clr = 4'hF;
        tick();
        check("clrall_flag", bus.flag, 4'h0);
        check("clrall_irq",  bus.irq,  1'b0);
        bus.clr = 4'h0;
        ticks(3);
        tick();
        check("fallall_fall",  bus.fall,  4'hF);
        check("fallall_pulse", bus.pulse, 4'h0);
        check("fallall_level", bus.level, 4'h0);
        check("fallall_flag",  bus.flag,  4'h0);
        ticks(2);

        // Single rising edge on channel 0.
        bus.din = 4'b0001;
        ticks(4);
        check("ch0_e3_rise", bus.rise, 4'h0);
        tick();
        check("ch0_e4_rise",  bus.rise,  4'b0001);
        check("ch0_e4_pulse", bus.pulse, 4'b0001);
        check("ch0_e4_level", bus.level, 4'b0001);
        check("ch0_e4_flag",  bus.flag,  4'b0001);
        tick();
        check("ch0_e5_rise",  bus.rise,  4'h0);
        check("ch0_e5_pulse", bus.pulse, 4'h0);
        check("ch0_e5_level", bus.level, 4'b0001);

        // Two-cycle glitch on channel 1 is rejected.
        bus.din = 4'b0011;
        ticks(2);
        bus.din = 4'b0001;
        seen = 4'h0;
        repeat (6) begin
            tick();
            seen = seen | bus.rise | bus.pulse | bus.flag | bus.level;
        end
        check("glitch_ch1", seen[1], 1'b0);

        // Three-cycle excursion on channel 1 commits.
        bus.din = 4'b0011;
        ticks(3);
        bus.din = 4'b0001;
        tick();
        check("hold3_e3_rise", bus.rise, 4'h0);
        tick();
        check("hold3_e4_rise",  bus.rise,  4'b0010);
        check("hold3_e4_level", bus.level, 4'b0011);
        ticks(5);
        check("hold3_back_level", bus.level, 4'b0001);
        bus.clr = 4'hF;
        tick();
        bus.clr = 4'h0;
        check("clr2_flag", bus.flag, 4'h0);

        // mode=10: only falls are reported.
        bus.mode = 2'b10;
        bus.din  = 4'b0101;
        ticks(4);
        tick();
        check("m10_rise",       bus.rise,  4'b0100);
        check("m10_rise_pulse", bus.pulse, 4'h0);
        check("m10_rise_flag",  bus.flag,  4'h0);
        tick();
        bus.din = 4'b0001;
        ticks(4);
        check("m10_f3_flag", bus.flag, 4'h0);
        tick();
        check("m10_fall",       bus.fall,  4'b0100);
        check("m10_fall_pulse", bus.pulse, 4'b0100);
        check("m10_fall_flag",  bus.flag,  4'b0100);
        check("m10_fall_irq",   bus.irq,   1'b1);
        ticks(2);
        bus.clr = 4'hF;
        tick();
        bus.clr = 4'h0;
        check("clr3_flag", bus.flag, 4'h0);

        // mode=00: level, rise and fall still move; no pulse, no flag.
        bus.mode = 2'b00;
        bus.din  = 4'b0101;
        ticks(5);
        check("m00_rise",       bus.rise,  4'b0100);
        check("m00_rise_pulse", bus.pulse, 4'h0);
        tick();
        bus.din = 4'b0001;
        ticks(5);
        check("m00_fall",       bus.fall,  4'b0100);
        check("m00_fall_pulse", bus.pulse, 4'h0);
        check("m00_flag",       bus.flag,  4'h0);
        check("m00_irq",        bus.irq,   1'b0);
        ticks(2);

        // Clear collision: clr[0] on the edge of a new pulse[0] loses to the event.
        bus.mode = 2'b11;
        bus.din  = 4'b0000;
        ticks(5);
        check("col_fall_pulse", bus.pulse, 4'b0001);
        check("col_fall_flag",  bus.flag,  4'b0001);
        ticks(2);
        bus.din = 4'b0001;
        ticks(4);
        bus.clr = 4'b0001;
        tick();
        check("col_pulse", bus.pulse, 4'b0001);
        check("col_flag",  bus.flag,  4'b0001);
        tick();
        bus.clr = 4'h0;
        check("col_after_flag", bus.flag, 4'h0);
        check("col_after_irq",  bus.irq,  1'b0);

        // All four channels toggle together.
        bus.din = 4'b1110;
        ticks(5);
        check("multi_pulse", bus.pulse, 4'hF);
        check("multi_rise",  bus.rise,  4'b1110);
        check("multi_fall",  bus.fall,  4'b0001);
        check("multi_level", bus.level, 4'b1110);
        check("multi_flag",  bus.flag,  4'hF);
        bus.clr = 4'hF;
        tick();
        bus.clr = 4'h0;
        check("clr4_flag", bus.flag, 4'h0);

        // Reset while channel 0 has counted to 2 discards the transition.
        bus.din = 4'hF;
        ticks(4);
        check("mid_e3_pulse", bus.pulse, 4'h0);
        check("mid_e3_level", bus.level, 4'b1110);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("mid_rst_level", bus.level, 4'h0);
        check("mid_rst_pulse", bus.pulse, 4'h0);
        check("mid_rst_flag",  bus.flag,  4'h0);
        seen = 4'h0;
        repeat (4) begin
            tick();
            seen = seen | bus.pulse | bus.rise;
        end
        check("mid_quiet", seen, 4'h0);
        tick();
        check("mid_k4_rise",  bus.rise,  4'hF);
        check("mid_k4_pulse", bus.pulse, 4'hF);
        check("mid_k4_level", bus.level, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised multi-channel edge detector, the successor to the single-bit edge detector. Each of WIDTH asynchronous inputs passes through a configurable synchroniser and a debounce filter. The block then reports rising and falling edges as single-cycle pulses, gated by a runtime mode. It keeps a sticky per-channel event flag with write-1-to-clear, plus a combined interrupt, for use by a polling or interrupt-driven controller.

## Interface
- WIDTH, 4: number of independent channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (0..4). A value of 0 bypasses the synchroniser, for inputs that are already synchronous.
- FILTER_LEN, 3: consecutive cycles a new input value must hold before it is accepted (1..255). A value of 1 means no debounce.

- clk  in  1  single clock; all flops are clocked on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- din  in  WIDTH  raw channel inputs.
- mode  in  2  bit0 = report rising edges, bit1 = report falling edges. 00 = off, 11 = both.
- clr  in  WIDTH  write-1-to-clear for the sticky flags, sampled each cycle.
- level  out  WIDTH  filtered, registered level of each channel.
- rise  out  WIDTH  one-cycle pulse on an accepted 0->1 transition. Not gated by mode.
- fall  out  WIDTH  one-cycle pulse on an accepted 1->0 transition. Not gated by mode.
- pulse  out  WIDTH  (rise & mode[0]) | (fall & mode[1]), registered.
- flag  out  WIDTH  sticky event flags.
- irq  out  1  OR-reduction of flag (combinational from the flag registers).

## Operation
- **Synchroniser.** Each channel has its own SYNC_STAGES-deep flop chain. Its output is s[i]; when SYNC_STAGES = 0, s[i] = din[i].
- **Debounce counter.**
  - Each channel has a counter cnt[i], width clog2(FILTER_LEN+1).
  - If s[i] == level[i], cnt[i] is set to 0.
  - Otherwise cnt[i] increments.
  - At the edge where the increment would reach FILTER_LEN, the channel "commits": level[i] toggles and cnt[i] returns to 0.
  - The counter never exceeds FILTER_LEN-1 and never wraps.
- **Edge outputs.** On a commit edge:
  - rise[i] is set to the new level[i].
  - fall[i] is set to the old level[i].
  - pulse[i] is set to the same values gated by mode as sampled at that edge.
  - On all other edges, rise, fall and pulse are 0. Each pulse is exactly one cycle wide; a commit is followed by at least FILTER_LEN cycles with no further commit.
- **Sticky flags.**
  - Update rule: flag[i] <= (flag[i] & ~clr[i]) | pulse_next[i], where pulse_next[i] is the pulse value being registered at that edge.
  - If a clear and a new event land on the same edge, the event wins and the flag stays 1.
  - clr on a flag that is already 0 has no effect.
- **Mode changes.** A change to mode affects only commits at or after the edge where the new value is sampled. Flags already set are unaffected. mode = 00 still updates level, rise and fall.
- **Channel independence.** Channels are fully independent. Simultaneous commits on several channels produce simultaneous pulses.

## Timing
- **Reset.** While resetn = 0 at a rising edge, the following are all 0: synchroniser flops, cnt, level, rise, fall, pulse and flag. irq is therefore 0 one edge after reset is applied.
- **Reset mid-filter.** Asserting reset during a partial count discards the count. No pulse is produced for that transition.
- **Input held high through reset.** Because level resets to 0, a din held high across reset release produces a rise after the normal latency.
- **Latency.** If din[i] changes and is first sampled at edge k and then held, level, rise and pulse update at edge k + SYNC_STAGES + FILTER_LEN - 1. For SYNC_STAGES = 0 and FILTER_LEN = 1, the update happens at edge k itself.
- **Flag timing.** flag rises at the same edge as pulse, and irq follows in the same cycle. A clr sampled at edge m clears the flag at edge m.
- **Glitch rejection.** An input excursion shorter than FILTER_LEN cycles, measured at s[i], produces no commit. The counter resets on the first cycle that s[i] matches level again.

## Test plan
WIDTH=4, SYNC_STAGES=2, FILTER_LEN=3, mode=01 unless stated.
- **Reset.** Hold resetn=0 for 2 edges with din=4'hF, then release. Required: all outputs 0 during reset; rise=4'hF, pulse=4'hF and flag=4'hF exactly 4 edges after release; irq=1.
- **Single rising edge.** din[0] goes 0->1 and is held. Required: rise[0] and pulse[0] high for exactly one cycle at sampling edge + 4; level[0]=1 from then on; flag[0]=1.
- **Glitch.** din[1] high for 2 cycles, then low. Required: no rise, pulse or flag change on channel 1; level[1] stays 0. The same input held for 3 cycles produces rise[1].
- **Mode gating.** Set mode=10 and toggle din[2] 0->1->0, each level held 6 cycles. Required: rise[2] pulses but pulse[2] does not; fall[2] and pulse[2] pulse together; flag[2]=1 only after the fall. Repeat with mode=00: no pulse and no flag, but rise and fall still pulse.
- **Clear collision.** Set flag[0]=1, then assert clr[0] on the exact edge of a new pulse[0]. Required: flag[0] stays 1. A clr[0] on the next edge alone drives flag[0]=0 and irq=0.
- **Multi-channel and mid-filter reset.** Toggle din[3:0] simultaneously. Required: 4 simultaneous pulses. Then pulse resetn low for 1 edge while cnt[0]=2. Required: no pulse for that transition; the channel restarts its full 4-edge latency after release.
